sr_latch_driver: RTL and testbench



---
 rtl/sr_drv_pkg.sv | 17 +
 rtl/switch_debounce.sv | 56 +++++
 rtl/sr_latch_driver.sv | 136 +++++++++++++
 tb/tb_sr_latch_driver.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/sr_drv_pkg.sv
// Shared definitions for the SR latch drive stage: FSM encoding and defaults.
// Latency: none (types and constants only).
// Backpressure: none.
package sr_drv_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SET_PULSE = 2'd1,
        CLR_PULSE = 2'd2,
        GAP       = 2'd3
    } drv_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_PULSE_CYCLES    = 2;
    localparam int DEF_CNT_W           = 8;

endpackage : sr_drv_pkg

// File: rtl/switch_debounce.sv
// Synchronizes and debounces one raw push-button, emits a one-cycle rise pulse.
// Latency: rise_o high DEBOUNCE_CYCLES+2 edges after the input is first sampled high.
// Backpressure: none; the button is free-running and cannot be stalled.
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic rise_o
);

    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic             deb_d;
    logic             deb_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Debounced level flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Two-flop synchronizer, debounce state and delayed level for edge detect.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= btn_i;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q      <= cnt_d;
        end
    end

    // Releases (falling debounced edges) intentionally produce nothing.
    assign rise_o = deb_q & ~deb_prev_q;

endmodule : switch_debounce

// File: rtl/sr_latch_driver.sv
// Turns debounced set/clear presses into fixed-width active-low pulses for a NAND SR latch.
// Latency: s_n/r_n fall DEBOUNCE_CYCLES+3 edges after the button is first sampled high.
// Backpressure: presses during a pulse are held pending; simultaneous requests are dropped with conflict.
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic set_btn,
    input  logic clr_btn,
    output logic s_n,
    output logic r_n,
    output logic busy,
    output logic conflict
);

    logic             set_req;
    logic             clr_req;
    logic             eff_set;
    logic             eff_clr;
    logic             launch;
    drv_state_e       state_q;
    drv_state_e       state_d;
    logic [CNT_W-1:0] pcnt_q;
    logic [CNT_W-1:0] pcnt_d;
    logic             pend_set_q;
    logic             pend_set_d;
    logic             pend_clr_q;
    logic             pend_clr_d;
    logic             conflict_d;
    logic             s_n_q;
    logic             r_n_q;
    logic             busy_q;
    logic             conflict_q;

    switch_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_set_deb (
        .clk_i  (clk),
        .rst_i  (rst),
        .btn_i  (set_btn),
        .rise_o (set_req)
    );

    switch_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_clr_deb (
        .clk_i  (clk),
        .rst_i  (rst),
        .btn_i  (clr_btn),
        .rise_o (clr_req)
    );

    assign eff_set = set_req | pend_set_q;
    assign eff_clr = clr_req | pend_clr_q;

    // Next-state: pulses run PULSE_CYCLES, then one GAP; requests are arbitrated in IDLE and at GAP exit.
    always_comb begin
        state_d    = state_q;
        pcnt_d     = pcnt_q;
        pend_set_d = pend_set_q;
        pend_clr_d = pend_clr_q;
        conflict_d = 1'b0;
        launch     = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                launch = 1'b1;
            end
            SET_PULSE, CLR_PULSE: begin
                pend_set_d = pend_set_q | set_req;
                pend_clr_d = pend_clr_q | clr_req;
                if (pcnt_q == '0) begin
                    state_d = GAP;
                end else begin
                    pcnt_d = pcnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (launch) begin
            if (eff_set && eff_clr) begin
                conflict_d = 1'b1;
                pend_set_d = 1'b0;
                pend_clr_d = 1'b0;
                state_d    = IDLE;
            end else if (eff_set) begin
                state_d    = SET_PULSE;
                pcnt_d     = CNT_W'(PULSE_CYCLES - 1);
                pend_set_d = 1'b0;
            end else if (eff_clr) begin
                state_d    = CLR_PULSE;
                pcnt_d     = CNT_W'(PULSE_CYCLES - 1);
                pend_clr_d = 1'b0;
            end else begin
                state_d    = IDLE;
            end
        end
    end

    // State, counters and outputs; drives are decoded from next-state so they never overlap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pcnt_q     <= '0;
            pend_set_q <= 1'b0;
            pend_clr_q <= 1'b0;
            s_n_q      <= 1'b1;
            r_n_q      <= 1'b1;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            pend_set_q <= pend_set_d;
            pend_clr_q <= pend_clr_d;
            s_n_q      <= (state_d != SET_PULSE);
            r_n_q      <= (state_d != CLR_PULSE);
            busy_q     <= (state_d != IDLE);
            conflict_q <= conflict_d;
        end
    end

    assign s_n      = s_n_q;
    assign r_n      = r_n_q;
    assign busy     = busy_q;
    assign conflict = conflict_q;

endmodule : sr_latch_driver

// File: tb/tb_sr_latch_driver.sv
// Directed and random bench for sr_latch_driver with D=4, P=2.
// Latency: checks sample #1 after each rising edge or at the falling edge.
// Backpressure: not applicable.
module tb_sr_latch_driver;

    localparam int P = 2;

    logic clk;
    logic rst;
    logic set_btn;
    logic clr_btn;
    logic s_n;
    logic r_n;
    logic busy;
    logic conflict;

    int checks;
    int failures;
    int s_run;
    int r_run;

    sr_latch_driver #(
        .DEBOUNCE_CYCLES (4),
        .PULSE_CYCLES    (P),
        .CNT_W           (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .set_btn  (set_btn),
        .clr_btn  (clr_btn),
        .s_n      (s_n),
        .r_n      (r_n),
        .busy     (busy),
        .conflict (conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s at %0t: observed=%b expected=%b", tag, $time, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic e_s, input logic e_r,
                              input logic e_b, input logic e_c);
        check({tag, ".s_n"}, s_n, e_s);
        check({tag, ".r_n"}, r_n, e_r);
        check({tag, ".busy"}, busy, e_b);
        check({tag, ".conflict"}, conflict, e_c);
    endtask

    task automatic idle_wait(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check_outs(tag, 1'b1, 1'b1, 1'b0, 1'b0);
        end
    endtask

    // Continuous protocol monitor: never both low, pulse width exact, gap after each pulse.
    always @(negedge clk) begin
        if (rst) begin
            s_run = 0;
            r_run = 0;
        end else begin
            check("never_both_low", s_n | r_n, 1'b1);
            if (!s_n) begin
                s_run++;
            end else if (s_run != 0) begin
                check("s_pulse_width", s_run == P, 1'b1);
                check("s_gap_after", r_n, 1'b1);
                s_run = 0;
            end
            if (!r_n) begin
                r_run++;
            end else if (r_run != 0) begin
                check("r_pulse_width", r_run == P, 1'b1);
                check("r_gap_after", s_n, 1'b1);
                r_run = 0;
            end
        end
    end

    initial begin
        bit [7:0] bpat;
        checks   = 0;
        failures = 0;
        s_run    = 0;
        r_run    = 0;
        rst      = 1'b1;
        set_btn  = 1'b0;
        clr_btn  = 1'b0;

        // Reset state before any clock edge.
        #2;
        check_outs("reset_state", 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;
        idle_wait("post_reset_idle", 3);

        // Clean set press.
        set_btn = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            step();
            check_outs($sformatf("clean_set_e%0d", e),
                       !(e == 7 || e == 8), 1'b1, (e >= 7 && e <= 9), 1'b0);
        end
        set_btn = 1'b0;
        idle_wait("clean_set_release", 12);

        // Bounce shorter than the debounce window.
        bpat = 8'b11100111;
        for (int i = 7; i >= 0; i--) begin
            set_btn = bpat[i];
            step();
            check_outs($sformatf("bounce_%0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
        end
        set_btn = 1'b0;
        idle_wait("bounce_tail", 10);

        // Simultaneous press.
        set_btn = 1'b1;
        clr_btn = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step();
            check_outs($sformatf("simul_e%0d", e), 1'b1, 1'b1, 1'b0, (e == 7));
        end
        set_btn = 1'b0;
        clr_btn = 1'b0;
        idle_wait("simul_release", 12);

        // Overlapping requests: clear queued behind set.
        set_btn = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            if (e == 3) clr_btn = 1'b1;
            step();
            check_outs($sformatf("overlap_e%0d", e),
                       !(e == 7 || e == 8), !(e == 10 || e == 11),
                       (e >= 7 && e <= 12), 1'b0);
        end
        set_btn = 1'b0;
        clr_btn = 1'b0;
        idle_wait("overlap_release", 12);

        // Reset mid-pulse releases the drive without a clock edge.
        set_btn = 1'b1;
        for (int e = 1; e <= 7; e++) step();
        check("midpulse_pre.s_n", s_n, 1'b0);
        check("midpulse_pre.busy", busy, 1'b1);
        #2;
        rst     = 1'b1;
        set_btn = 1'b0;
        #1;
        check_outs("midpulse_rst", 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        idle_wait("after_midpulse_rst", 12);

        // Random bouncing with occasional reset; the monitor checks protocol.
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(5, 0) == 0) set_btn = ~set_btn;
            if ($urandom_range(5, 0) == 0) clr_btn = ~clr_btn;
            rst = ($urandom_range(399, 0) == 0);
            step();
        end
        rst     = 1'b0;
        set_btn = 1'b0;
        clr_btn = 1'b0;
        for (int i = 0; i < 30; i++) step();
        check_outs("stress_settle", 1'b1, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sr_latch_driver
